// File: rtl/bht_multidomain.sv
// Bimodal branch history table with a stored target per entry, replicated
// into NUM_DOMAINS isolated tables. Lookups are registered (1-cycle latency),
// updates are applied at the end of the cycle they are presented in. A
// sequential sweep engine clears one domain on request and every domain
// after reset; a domain under sweep neither predicts nor trains.
module bht_multidomain #(
   parameter  int IDX_W       = 4,
   parameter  int CTR_W       = 2,
   parameter  int TARG_W      = 32,
   parameter  int NUM_DOMAINS = 2,
   localparam int DOM_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              lookup_valid_i,
   input  logic [IDX_W-1:0]  lookup_idx_i,
   input  logic [DOM_W-1:0]  lookup_dom_i,
   output logic              pred_valid_o,
   output logic              pred_taken_o,
   output logic [TARG_W-1:0] pred_targ_o,
   input  logic              update_en_i,
   input  logic [IDX_W-1:0]  update_idx_i,
   input  logic [DOM_W-1:0]  update_dom_i,
   input  logic              update_taken_i,
   input  logic [TARG_W-1:0] update_targ_i,
   input  logic              flush_req_i,
   input  logic [DOM_W-1:0]  flush_dom_i,
   output logic              busy_o,
   output logic              flush_done_o
);

   localparam int               DEPTH     = 1 << IDX_W;
   localparam logic [IDX_W-1:0] PTR_LAST  = {IDX_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_SAT   = {CTR_W{1'b1}};
   localparam logic [CTR_W-1:0] CTR_ZERO  = {CTR_W{1'b0}};
   localparam logic [DOM_W:0]   DOM_LIMIT = (DOM_W + 1)'(NUM_DOMAINS);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_FLUSH_ONE = 2'd1,
      ST_FLUSH_ALL = 2'd2
   } state_t;

   state_t             state_r, state_nx_s;
   logic [IDX_W-1:0]   ptr_r, ptr_nx_s;
   logic [DOM_W-1:0]   fdom_r, fdom_nx_s;
   logic               busy_r;
   logic               done_r, done_nx_s;

   logic               pred_valid_r;
   logic               pred_taken_r;
   logic [TARG_W-1:0]  pred_targ_r;

   logic               lk_ok_s;
   logic [DOM_W-1:0]   lk_dom_s;
   logic               up_ok_s;
   logic [DOM_W-1:0]   up_dom_s;
   logic [CTR_W-1:0]   up_ctr_old_s;
   logic [CTR_W-1:0]   up_ctr_nx_s;

   // Table storage: no reset, the sweep engine is what clears it.
   logic [CTR_W-1:0]   ctr_mem_r  [NUM_DOMAINS][DEPTH];
   logic [TARG_W-1:0]  targ_mem_r [NUM_DOMAINS][DEPTH];

   // A domain id is only meaningful below NUM_DOMAINS.
   function automatic logic dom_legal(input logic [DOM_W-1:0] dom);
      return ({1'b0, dom} < DOM_LIMIT);
   endfunction

   // A domain is blocked while any sweep covering it is in progress.
   function automatic logic dom_affected(input state_t st,
                                         input logic [DOM_W-1:0] lock_dom,
                                         input logic [DOM_W-1:0] dom);
      logic hit;
      case (st)
         ST_IDLE:      hit = 1'b0;
         ST_FLUSH_ONE: hit = (dom == lock_dom);
         ST_FLUSH_ALL: hit = 1'b1;
         default:      hit = 1'b1;
      endcase
      return hit;
   endfunction

   // Qualify lookup and update requests; clamp illegal domains so reads stay in range.
   always_comb begin
      lk_ok_s  = 1'b0;
      lk_dom_s = {DOM_W{1'b0}};
      up_ok_s  = 1'b0;
      up_dom_s = {DOM_W{1'b0}};
      if (dom_legal(lookup_dom_i)) begin
         lk_dom_s = lookup_dom_i;
         lk_ok_s  = lookup_valid_i && !dom_affected(state_r, fdom_r, lookup_dom_i);
      end else begin
         lk_dom_s = {DOM_W{1'b0}};
         lk_ok_s  = 1'b0;
      end
      if (dom_legal(update_dom_i)) begin
         up_dom_s = update_dom_i;
         up_ok_s  = update_en_i && !dom_affected(state_r, fdom_r, update_dom_i);
      end else begin
         up_dom_s = {DOM_W{1'b0}};
         up_ok_s  = 1'b0;
      end
   end

   // Saturating counter step for the entry being trained.
   always_comb begin
      up_ctr_old_s = ctr_mem_r[up_dom_s][update_idx_i];
      up_ctr_nx_s  = up_ctr_old_s;
      if (update_taken_i) begin
         if (up_ctr_old_s != CTR_SAT) begin
            up_ctr_nx_s = up_ctr_old_s + CTR_W'(1);
         end else begin
            up_ctr_nx_s = up_ctr_old_s;
         end
      end else begin
         if (up_ctr_old_s != CTR_ZERO) begin
            up_ctr_nx_s = up_ctr_old_s - CTR_W'(1);
         end else begin
            up_ctr_nx_s = up_ctr_old_s;
         end
      end
   end

   // Sweep engine next state: idle accepts a legal request, sweeps walk ptr to the last entry.
   always_comb begin
      state_nx_s = state_r;
      ptr_nx_s   = ptr_r;
      fdom_nx_s  = fdom_r;
      done_nx_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (flush_req_i && dom_legal(flush_dom_i)) begin
               state_nx_s = ST_FLUSH_ONE;
               ptr_nx_s   = {IDX_W{1'b0}};
               fdom_nx_s  = flush_dom_i;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_FLUSH_ONE, ST_FLUSH_ALL: begin
            if (ptr_r == PTR_LAST) begin
               state_nx_s = ST_IDLE;
               ptr_nx_s   = {IDX_W{1'b0}};
            end else begin
               ptr_nx_s   = ptr_r + IDX_W'(1);
            end
         end
         default: begin
            state_nx_s = ST_FLUSH_ALL;
            ptr_nx_s   = {IDX_W{1'b0}};
         end
      endcase
      // The done flag is registered, so it is armed one cycle ahead of the last sweep cycle.
      if ((state_nx_s != ST_IDLE) && (ptr_nx_s == PTR_LAST)) begin
         done_nx_s = 1'b1;
      end else begin
         done_nx_s = 1'b0;
      end
   end

   // Sweep engine state; reset always restarts a full clear from entry 0.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= ST_FLUSH_ALL;
         ptr_r   <= {IDX_W{1'b0}};
         fdom_r  <= {DOM_W{1'b0}};
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         ptr_r   <= ptr_nx_s;
         fdom_r  <= fdom_nx_s;
         busy_r  <= (state_nx_s != ST_IDLE);
         done_r  <= done_nx_s;
      end
   end

   // Table writes: swept domains clear entry ptr, other domains accept training.
   always_ff @(posedge clk_i) begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
         if (dom_affected(state_r, fdom_r, DOM_W'(d))) begin
            ctr_mem_r[d][ptr_r]  <= CTR_ZERO;
            targ_mem_r[d][ptr_r] <= {TARG_W{1'b0}};
         end else if (up_ok_s && (up_dom_s == DOM_W'(d))) begin
            ctr_mem_r[d][update_idx_i] <= up_ctr_nx_s;
            if (update_taken_i) begin
               targ_mem_r[d][update_idx_i] <= update_targ_i;
            end
         end
      end
   end

   // Registered prediction; reads the pre-update table contents (no bypass).
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pred_valid_r <= 1'b0;
         pred_taken_r <= 1'b0;
         pred_targ_r  <= {TARG_W{1'b0}};
      end else if (lk_ok_s) begin
         pred_valid_r <= 1'b1;
         pred_taken_r <= ctr_mem_r[lk_dom_s][lookup_idx_i][CTR_W-1];
         pred_targ_r  <= targ_mem_r[lk_dom_s][lookup_idx_i];
      end else begin
         pred_valid_r <= 1'b0;
         pred_taken_r <= 1'b0;
         pred_targ_r  <= {TARG_W{1'b0}};
      end
   end

   assign pred_valid_o = pred_valid_r;
   assign pred_taken_o = pred_taken_r;
   assign pred_targ_o  = pred_targ_r;
   assign busy_o       = busy_r;
   assign flush_done_o = done_r;

endmodule

// File: tb/tb_bht_multidomain.sv
// Self-checking bench for bht_multidomain (IDX_W=4, CTR_W=2, TARG_W=32,
// NUM_DOMAINS=3 so that domain id 3 is encodable but illegal). A small
// behavioural table model predicts every cycle's registered outputs; the
// expectation is queued when the cycle is driven and compared once the
// cycle's outputs have been captured.
module tb_bht_multidomain;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        lookup_valid_i = 1'b0;
   logic [3:0]  lookup_idx_i = 4'd0;
   logic [1:0]  lookup_dom_i = 2'd0;
   logic        pred_valid_o;
   logic        pred_taken_o;
   logic [31:0] pred_targ_o;
   logic        update_en_i = 1'b0;
   logic [3:0]  update_idx_i = 4'd0;
   logic [1:0]  update_dom_i = 2'd0;
   logic        update_taken_i = 1'b0;
   logic [31:0] update_targ_i = 32'd0;
   logic        flush_req_i = 1'b0;
   logic [1:0]  flush_dom_i = 2'd0;
   logic        busy_o;
   logic        flush_done_o;

   typedef struct packed {
      logic        v;
      logic        t;
      logic [31:0] g;
   } pred_t;

   pred_t       exp_q[$];
   pred_t       obs_q[$];
   logic [1:0]  m_ctr  [4][16];
   logic [31:0] m_targ [4][16];
   logic [3:0]  m_aff = 4'b0000;
   int          n_pass = 0;
   int          n_total = 0;

   always #5 clk_i = ~clk_i;

   bht_multidomain #(
      .IDX_W(4), .CTR_W(2), .TARG_W(32), .NUM_DOMAINS(3)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .lookup_valid_i(lookup_valid_i), .lookup_idx_i(lookup_idx_i), .lookup_dom_i(lookup_dom_i),
      .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o), .pred_targ_o(pred_targ_o),
      .update_en_i(update_en_i), .update_idx_i(update_idx_i), .update_dom_i(update_dom_i),
      .update_taken_i(update_taken_i), .update_targ_i(update_targ_i),
      .flush_req_i(flush_req_i), .flush_dom_i(flush_dom_i),
      .busy_o(busy_o), .flush_done_o(flush_done_o)
   );

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_lk(input logic [1:0] d, input logic [3:0] i);
      lookup_valid_i = 1'b1; lookup_dom_i = d; lookup_idx_i = i;
   endtask

   task automatic set_up(input logic [1:0] d, input logic [3:0] i, input logic t, input logic [31:0] g);
      update_en_i = 1'b1; update_dom_i = d; update_idx_i = i; update_taken_i = t; update_targ_i = g;
   endtask

   task automatic set_fl(input logic [1:0] d);
      flush_req_i = 1'b1; flush_dom_i = d;
   endtask

   task automatic model_clear(input int d);
      for (int i = 0; i < 16; i++) begin
         m_ctr[d][i] = 2'd0; m_targ[d][i] = 32'd0;
      end
   endtask

   // One clock cycle: queue the predicted output (pre-update table), train the model, capture the DUT.
   task automatic step();
      pred_t e;
      e = '0;
      if (lookup_valid_i && (lookup_dom_i < 2'd3) && !m_aff[lookup_dom_i])
         e = {1'b1, m_ctr[lookup_dom_i][lookup_idx_i][1], m_targ[lookup_dom_i][lookup_idx_i]};
      exp_q.push_back(e);
      if (update_en_i && (update_dom_i < 2'd3) && !m_aff[update_dom_i]) begin
         if (update_taken_i) begin
            if (m_ctr[update_dom_i][update_idx_i] != 2'd3)
               m_ctr[update_dom_i][update_idx_i] = m_ctr[update_dom_i][update_idx_i] + 2'd1;
            m_targ[update_dom_i][update_idx_i] = update_targ_i;
         end else if (m_ctr[update_dom_i][update_idx_i] != 2'd0) begin
            m_ctr[update_dom_i][update_idx_i] = m_ctr[update_dom_i][update_idx_i] - 2'd1;
         end
      end
      tick();
      obs_q.push_back({pred_valid_o, pred_taken_o, pred_targ_o});
      lookup_valid_i = 1'b0; update_en_i = 1'b0; flush_req_i = 1'b0;
   endtask

   task automatic test_reset();
      pred_t e, o;
      int n = 0;
      rst_ni = 1'b0;
      tick(); tick();
      n_total++;
      if ({busy_o, flush_done_o, pred_valid_o, pred_taken_o, pred_targ_o} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0})
         $display("FAIL reset_state: busy=%b done=%b v=%b t=%b targ=%h, want busy=1 done=0 v=0 t=0 targ=0",
                  busy_o, flush_done_o, pred_valid_o, pred_taken_o, pred_targ_o);
      else n_pass++;
      m_aff = 4'b0111;
      rst_ni = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         n_total++;
         if (busy_o !== 1'b1 || flush_done_o !== (k == 16))
            $display("FAIL reset_sweep_flags cycle %0d: busy=%b done=%b, want busy=1 done=%b", k, busy_o, flush_done_o, (k == 16));
         else n_pass++;
         set_lk(2'(k % 3), 4'(k));
         step();
      end
      m_aff = 4'b0000;
      n_total++;
      if (busy_o !== 1'b0 || flush_done_o !== 1'b0)
         $display("FAIL reset_sweep_end: busy=%b done=%b, want busy=0 done=0", busy_o, flush_done_o);
      else n_pass++;
      for (int d = 0; d < 3; d++) begin
         set_lk(2'(d), 4'(d * 5));
         step();
      end
      step();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL reset_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   task automatic test_counter();
      pred_t e, o;
      int n = 0;
      for (int i = 0; i < 3; i++) begin
         set_up(2'd1, 4'd5, 1'b1, 32'h0000_1000); step();
      end
      set_lk(2'd1, 4'd5); step();
      set_up(2'd1, 4'd5, 1'b1, 32'h0000_1004); step();
      set_lk(2'd1, 4'd5); step();
      for (int i = 0; i < 2; i++) begin
         set_up(2'd1, 4'd5, 1'b0, 32'hDEAD_BEEF); step();
         set_lk(2'd1, 4'd5); step();
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL counter_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   task automatic test_isolation();
      pred_t e, o;
      int n = 0;
      set_up(2'd0, 4'd3, 1'b1, 32'h0000_3030); step();
      set_up(2'd0, 4'd3, 1'b1, 32'h0000_3030); step();
      set_lk(2'd0, 4'd3); step();
      set_lk(2'd1, 4'd3); step();
      set_lk(2'd2, 4'd3); step();
      set_lk(2'd1, 4'd5); step();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL isolation_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   task automatic test_same_cycle();
      pred_t e, o;
      int n = 0;
      set_up(2'd0, 4'd7, 1'b1, 32'h0000_7000); step();
      set_up(2'd0, 4'd7, 1'b1, 32'h0000_7070); set_lk(2'd0, 4'd7); step();
      set_lk(2'd0, 4'd7); step();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL same_cycle_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   task automatic test_flush_one();
      pred_t e, o;
      int n = 0;
      n_total++;
      if (busy_o !== 1'b0) $display("FAIL flush_idle_busy: busy=%b, want 0", busy_o);
      else n_pass++;
      set_up(2'd1, 4'd9, 1'b1, 32'h0000_9999); set_fl(2'd1); set_lk(2'd0, 4'd3); step();
      m_aff = 4'b0010;
      for (int k = 1; k <= 16; k++) begin
         n_total++;
         if (busy_o !== 1'b1 || flush_done_o !== (k == 16))
            $display("FAIL flush_sweep_flags cycle %0d: busy=%b done=%b, want busy=1 done=%b", k, busy_o, flush_done_o, (k == 16));
         else n_pass++;
         if (k % 2 == 0) set_lk(2'd0, 4'd3); else set_lk(2'd1, 4'd9);
         if (k == 8) set_up(2'd0, 4'd2, 1'b1, 32'h0000_2222);
         else set_up(2'd1, 4'd9, 1'b1, 32'h0000_BAD9);
         if (k == 5) set_fl(2'd0);
         step();
      end
      m_aff = 4'b0000;
      model_clear(1);
      n_total++;
      if (busy_o !== 1'b0 || flush_done_o !== 1'b0)
         $display("FAIL flush_sweep_end: busy=%b done=%b, want busy=0 done=0", busy_o, flush_done_o);
      else n_pass++;
      for (int j = 0; j < 6; j++) begin
         case (j)
            0: set_lk(2'd1, 4'd9);
            1: set_lk(2'd1, 4'd5);
            2: set_lk(2'd0, 4'd3);
            3: set_lk(2'd0, 4'd7);
            4: set_lk(2'd0, 4'd2);
            default: set_lk(2'd2, 4'd3);
         endcase
         step();
         n_total++;
         if (busy_o !== 1'b0) $display("FAIL flush_dropped_req post-cycle %0d: busy=%b, want 0", j, busy_o);
         else n_pass++;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL flush_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   task automatic test_illegal_domain();
      pred_t e, o;
      int n = 0;
      set_up(2'd0, 4'd4, 1'b1, 32'h0000_4444); step();
      set_lk(2'd3, 4'd4); set_up(2'd3, 4'd4, 1'b1, 32'h0000_BAD0); step();
      set_up(2'd3, 4'd4, 1'b1, 32'h0000_BAD1); step();
      set_up(2'd3, 4'd4, 1'b1, 32'h0000_BAD1); step();
      for (int d = 0; d < 3; d++) begin
         set_lk(2'(d), 4'd4); step();
      end
      set_fl(2'd3); step();
      n_total++;
      if (busy_o !== 1'b0) $display("FAIL illegal_flush_busy: busy=%b, want 0", busy_o);
      else n_pass++;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL illegal_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   task automatic test_midsweep_reset();
      pred_t e, o;
      int n = 0;
      set_lk(2'd0, 4'd4); step();
      rst_ni = 1'b0;
      #1;
      n_total++;
      if (busy_o !== 1'b1 || pred_valid_o !== 1'b0 || flush_done_o !== 1'b0)
         $display("FAIL async_reset: busy=%b v=%b done=%b, want busy=1 v=0 done=0", busy_o, pred_valid_o, flush_done_o);
      else n_pass++;
      tick();
      rst_ni = 1'b1;
      m_aff = 4'b0111;
      for (int k = 1; k <= 7; k++) begin
         n_total++;
         if (busy_o !== 1'b1 || flush_done_o !== 1'b0)
            $display("FAIL partial_sweep_flags cycle %0d: busy=%b done=%b, want busy=1 done=0", k, busy_o, flush_done_o);
         else n_pass++;
         step();
      end
      rst_ni = 1'b0;
      #1;
      n_total++;
      if (busy_o !== 1'b1 || flush_done_o !== 1'b0)
         $display("FAIL midsweep_reset: busy=%b done=%b, want busy=1 done=0", busy_o, flush_done_o);
      else n_pass++;
      tick();
      rst_ni = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         n_total++;
         if (busy_o !== 1'b1 || flush_done_o !== (k == 16))
            $display("FAIL restart_sweep_flags cycle %0d: busy=%b done=%b, want busy=1 done=%b", k, busy_o, flush_done_o, (k == 16));
         else n_pass++;
         set_lk(2'd0, 4'd4);
         step();
      end
      m_aff = 4'b0000;
      for (int d = 0; d < 3; d++) model_clear(d);
      n_total++;
      if (busy_o !== 1'b0 || flush_done_o !== 1'b0)
         $display("FAIL restart_sweep_end: busy=%b done=%b, want busy=0 done=0", busy_o, flush_done_o);
      else n_pass++;
      set_lk(2'd0, 4'd4); step();
      set_lk(2'd0, 4'd3); step();
      set_lk(2'd1, 4'd5); step();
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); n_total++;
         if (o !== e) $display("FAIL midreset_pred #%0d: got v=%b t=%b targ=%h, want v=%b t=%b targ=%h", n, o.v, o.t, o.g, e.v, e.t, e.g);
         else n_pass++;
         n++;
      end
   endtask

   initial begin
      for (int d = 0; d < 4; d++) model_clear(d);
      test_reset();
      test_counter();
      test_isolation();
      test_same_cycle();
      test_flush_one();
      test_illegal_domain();
      test_midsweep_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
